// File: rtl/bcd_counter.sv
// Multi-digit registered BCD up/down counter with synchronous validated load,
// wrap/saturate end-of-range handling and cascade outputs for 7-seg drive.

// One BCD digit of the ripple increment/decrement chain.
module bcd_digit (
  input  logic [3:0] i_digit,
  input  logic       i_up,
  input  logic       i_cin,
  output logic [3:0] o_digit,
  output logic       o_cout
);
  // Step the digit when the lower digits ripple into it; 9->0 up, 0->9 down.
  always_comb begin
    o_digit = i_digit;
    o_cout  = 1'b0;
    if (i_cin) begin
      if (i_up) begin
        if (i_digit == 4'd9) begin
          o_digit = 4'd0;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit + 4'd1;
        end
      end else begin
        if (i_digit == 4'd0) begin
          o_digit = 4'd9;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_counter #(
  parameter int                  DIGITS     = 3,
  parameter int                  WRAP       = 1,
  parameter logic [4*DIGITS-1:0] MAXVAL_HEX = {DIGITS{4'h9}}
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_up,
  input  logic                i_load,
  input  logic [4*DIGITS-1:0] i_load_value,
  output logic [4*DIGITS-1:0] o_count,
  output logic                o_carry_out,
  output logic                o_terminal_count,
  output logic                o_load_error
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]      r_count;
  logic              r_carry;
  logic              r_load_error;

  logic [W-1:0]      w_step;
  logic [DIGITS:0]   w_carry;
  logic [DIGITS-1:0] w_digit_ok;
  logic              w_load_ok;
  logic              w_at_max;
  logic              w_at_zero;
  logic              w_underflow;

  // Digit 0 always steps; higher digits step only when every lower digit rolls.
  assign w_carry[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
        .i_digit (r_count[4*g +: 4]),
        .i_up    (i_up),
        .i_cin   (w_carry[g]),
        .o_digit (w_step[4*g +: 4]),
        .o_cout  (w_carry[g+1])
      );
      assign w_digit_ok[g] = (i_load_value[4*g +: 4] <= 4'd9);
    end
  endgenerate

  // With all digits valid BCD, a plain unsigned compare orders values correctly.
  assign w_load_ok   = (&w_digit_ok) && (i_load_value <= MAXVAL_HEX);
  assign w_at_max    = (r_count == MAXVAL_HEX);
  assign w_at_zero   = (r_count == '0);
  // Counting down, a borrow out of the top digit means every digit was 0.
  assign w_underflow = ~i_up & w_carry[DIGITS];

  // Count register: reset > load > enable; pulses default low each cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count      <= '0;
      r_carry      <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_carry      <= 1'b0;
      r_load_error <= 1'b0;
      if (i_load) begin
        if (w_load_ok) r_count      <= i_load_value;
        else           r_load_error <= 1'b1;
      end else if (i_enable) begin
        if (i_up) begin
          if (w_at_max) begin
            r_carry <= 1'b1;
            if (WRAP != 0) r_count <= '0;
          end else begin
            r_count <= w_step;
          end
        end else begin
          if (w_underflow) begin
            r_carry <= 1'b1;
            if (WRAP != 0) r_count <= MAXVAL_HEX;
          end else begin
            r_count <= w_step;
          end
        end
      end
    end
  end

  assign o_count          = r_count;
  assign o_carry_out      = r_carry;
  assign o_load_error     = r_load_error;
  assign o_terminal_count = i_up ? w_at_max : w_at_zero;
endmodule

// File: tb/tb_bcd_counter.sv
module tb_bcd_counter;
  logic        clk, rst, en, up, ld;
  logic [11:0] lv;
  logic [11:0] cnt_w, cnt_s;
  logic        co_w, co_s, tc_w, tc_s, le_w, le_s;

  int checks = 0;
  int errors = 0;
  int m_w = 0;
  int m_s = 0;

  typedef struct {
    logic [11:0] cnt;
    logic        co;
    logic        le;
  } exp_t;
  exp_t q_w[$];
  exp_t q_s[$];

  bcd_counter #(.DIGITS(3), .WRAP(1)) u_wrap (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_up(up), .i_load(ld),
    .i_load_value(lv), .o_count(cnt_w), .o_carry_out(co_w),
    .o_terminal_count(tc_w), .o_load_error(le_w)
  );

  bcd_counter #(.DIGITS(3), .WRAP(0), .MAXVAL_HEX(12'h999)) u_sat (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_up(up), .i_load(ld),
    .i_load_value(lv), .o_count(cnt_s), .o_carry_out(co_s),
    .o_terminal_count(tc_s), .o_load_error(le_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] b;
    b[3:0]  = 4'(v % 10);
    b[7:4]  = 4'((v / 10) % 10);
    b[11:8] = 4'((v / 100) % 10);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour in plain decimal arithmetic.
  task automatic model(input bit wrap, inout int m, input bit e, input bit u,
                       input bit l, input logic [11:0] v,
                       output logic co, output logic le);
    bit valid;
    int val;
    logic [3:0] nib;
    co = 1'b0;
    le = 1'b0;
    if (l) begin
      valid = 1'b1;
      val   = 0;
      for (int i = 2; i >= 0; i--) begin
        nib = v[4*i +: 4];
        if (nib > 4'd9) valid = 1'b0;
        val = val * 10 + int'(nib);
      end
      if (valid && val <= 999) m = val;
      else le = 1'b1;
    end else if (e) begin
      if (u) begin
        if (m == 999) begin co = 1'b1; if (wrap) m = 0; end
        else m = m + 1;
      end else begin
        if (m == 0) begin co = 1'b1; if (wrap) m = 999; end
        else m = m - 1;
      end
    end
  endtask

  // Drive one cycle of stimulus at negedge, score both instances after the edge.
  task automatic step(input bit e, input bit u, input bit l, input logic [11:0] v);
    exp_t x, y;
    en = e; up = u; ld = l; lv = v;
    model(1'b1, m_w, e, u, l, v, x.co, x.le);
    x.cnt = to_bcd(m_w);
    q_w.push_back(x);
    model(1'b0, m_s, e, u, l, v, y.co, y.le);
    y.cnt = to_bcd(m_s);
    q_s.push_back(y);
    @(posedge clk);
    #1;
    x = q_w.pop_front();
    y = q_s.pop_front();
    chk("wrap_count", cnt_w, x.cnt);
    chk("wrap_carry", 12'(co_w), 12'(x.co));
    chk("wrap_lderr", 12'(le_w), 12'(x.le));
    chk("wrap_tc", 12'(tc_w), 12'(u ? (m_w == 999) : (m_w == 0)));
    chk("sat_count", cnt_s, y.cnt);
    chk("sat_carry", 12'(co_s), 12'(y.co));
    chk("sat_lderr", 12'(le_s), 12'(y.le));
    chk("sat_tc", 12'(tc_s), 12'(u ? (m_s == 999) : (m_s == 0)));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; lv = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_count", cnt_w, 12'h000);
    chk("reset_carry", 12'(co_w), 12'h0);
    chk("reset_lderr", 12'(le_w), 12'h0);
    chk("reset_count_sat", cnt_s, 12'h000);
    rst = 1'b0;

    // Ripple carries across digits
    step(0, 1, 1, 12'h599);
    step(1, 1, 0, 12'h000);
    chk("inc_599", cnt_w, 12'h600);
    step(0, 1, 1, 12'h209);
    step(1, 1, 0, 12'h000);
    chk("inc_209", cnt_w, 12'h210);

    // Wrap up then wrap down; saturating instance holds
    step(0, 1, 1, 12'h999);
    step(1, 1, 0, 12'h000);
    chk("wrap_up_cnt", cnt_w, 12'h000);
    chk("wrap_up_co", 12'(co_w), 12'h1);
    step(1, 0, 0, 12'h000);
    chk("wrap_dn_cnt", cnt_w, 12'h999);
    chk("wrap_dn_co", 12'(co_w), 12'h1);

    // Borrow across digits, TC low at 100 counting down
    step(0, 0, 1, 12'h100);
    chk("tc_100_down", 12'(tc_w), 12'h0);
    step(1, 0, 0, 12'h000);
    chk("dec_100", cnt_w, 12'h099);

    // Saturation held for three cycles
    step(0, 1, 1, 12'h999);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 12'h000);
      chk("sat_hold", cnt_s, 12'h999);
      chk("sat_co", 12'(co_s), 12'h1);
    end
    step(0, 0, 1, 12'h000);
    step(1, 0, 0, 12'h000);
    chk("sat_zero_hold", cnt_s, 12'h000);

    // Invalid load rejected; load beats enable
    step(0, 1, 1, 12'h123);
    step(0, 1, 1, 12'h1A3);
    chk("bad_load_hold", cnt_w, 12'h123);
    chk("bad_load_err", 12'(le_w), 12'h1);
    step(0, 1, 1, 12'hF00);
    step(1, 1, 1, 12'h472);
    chk("load_over_en", cnt_w, 12'h472);
    chk("load_err_clear", 12'(le_w), 12'h0);

    // Random mix
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
           12'($urandom));

    // Asynchronous reset mid-cycle while counting
    step(0, 1, 1, 12'h345);
    step(1, 1, 0, 12'h000);
    en = 1'b1; up = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_w", cnt_w, 12'h000);
    chk("async_rst_s", cnt_s, 12'h000);
    m_w = 0;
    m_s = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 0, 12'h000);
    chk("after_rst", cnt_w, 12'h001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
Parametrised, registered multi-digit BCD up/down counter. It generalises the fixed 3-digit combinational BCD incrementor to N digits and adds a clocked count register, a direction control, a synchronous load with digit validation, and a selectable wrap/saturate mode. Each digit is a 4-bit BCD value (0..9). The block sits in the display/counting datapath and drives 7-segment decoders directly. TerminalCount and CarryOut allow higher-order instances to be cascaded.

Parameters:
DIGITS, 3, number of BCD digits; count width is 4*DIGITS; legal range 1..8
WRAP, 1, 1 = wrap at the end of the range; 0 = saturate at the end of the range
MAXVAL_HEX, all digits 9 (e.g. 12'h999), upper count limit as packed BCD; every digit must be ≤9

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Enable  input  1  advance the count by one step this cycle
Up  input  1  1 = count up, 0 = count down
Load  input  1  synchronous load request
LoadValue  input  4*DIGITS  packed BCD load value; digit 0 is in the LSBs
Count  output  4*DIGITS  registered packed BCD count
CarryOut  output  1  registered one-cycle pulse on wrap, or on a saturation attempt
TerminalCount  output  1  combinational: Count==MAXVAL_HEX when Up=1; Count==0 when Up=0
LoadError  output  1  registered one-cycle pulse when a Load is rejected

Behaviour:
- Reset (asynchronous, takes effect immediately while high): Count=0, CarryOut=0, LoadError=0.
- All register updates occur on the rising edge of Clock. Latency is one cycle from input to Count.
- CarryOut and LoadError default to 0 every cycle unless set by the rules below.
- Priority order: Reset > Load > Enable.
- Load=1:
  - If every LoadValue digit is ≤9 and LoadValue ≤ MAXVAL_HEX, then Count<=LoadValue.
  - Otherwise Count holds and LoadError=1 for one cycle.
  - Enable is ignored in any cycle where Load=1.
- Enable=1, Up=1, Count<MAXVAL_HEX:
  - Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - The carry chain is ripple-combinational within one cycle.
- Enable=1, Up=1, Count==MAXVAL_HEX:
  - WRAP=1: Count<=0 and CarryOut=1.
  - WRAP=0: Count holds and CarryOut=1.
- Enable=1, Up=0, Count>0:
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
- Enable=1, Up=0, Count==0:
  - WRAP=1: Count<=MAXVAL_HEX and CarryOut=1.
  - WRAP=0: Count holds and CarryOut=1.
- Enable=0, Load=0: Count holds.
- Up may change on any cycle; only the value sampled at the clock edge matters.
- Count never contains a digit >9 and never exceeds MAXVAL_HEX.
- TerminalCount is purely combinational from Count and Up, so a cascaded stage's Enable can be driven by (Enable & TerminalCount) of the lower stage.
- Reset asserted mid-count clears Count on assertion, independent of Clock. Counting resumes at the first rising edge after Reset deasserts.

Test Plan:
- DIGITS=3, WRAP=1. Reset, then Load 12'h599, then Enable with Up=1 → Count=12'h600, CarryOut=0. Repeat from Load 12'h209 → 12'h210.
- Load 12'h999, then Enable with Up=1 → Count=12'h000 and a one-cycle CarryOut pulse. Next cycle with Up=0 → Count=12'h999 with CarryOut=1.
- Load 12'h100, Up=0 → TerminalCount=0. Enable for one cycle → Count=12'h099, CarryOut=0.
- WRAP=0, Count=12'h999, Enable held with Up=1 for 3 cycles → Count stays 12'h999 and CarryOut is high on each of the 3 cycles.
- Load 12'h1A3 → LoadError pulses for 1 cycle and Count is unchanged. Load=1 together with Enable=1 and LoadValue 12'h472 → Count=12'h472 (no increment applied).
- Assert Reset asynchronously between clock edges while counting → Count=0 immediately. First Enable after release with Up=1 → Count=12'h001.
